// File: rtl/bram_matrix_loader_if.sv
// ---------------------------------------------------------------------------
// bram_matrix_loader_if
//
// Bundles the load-control handshake and the shared BRAM read bus of
// bram_matrix_loader.
//
// Signals:
//   start      sequencer -> loader   request a load (only looked at when idle)
//   base_addr  sequencer -> loader   first BRAM address, captured with start
//   transpose  sequencer -> loader   placement mode, captured with start
//   busy       loader -> sequencer   load in progress
//   done       loader -> sequencer   one-cycle pulse, matrices complete
//   bram_en    loader -> BRAM        read enable shared by all channels
//   bram_addr  loader -> BRAM        read address shared by all channels
//   bram_data  BRAM -> loader        NUM_CH x DATA_W read data, ch c at [c*DATA_W +: DATA_W]
//
// Handshake: start is accepted on a rising edge only while the loader is
// idle (busy=0 and done=0). From the next cycle busy is high until the last
// read word has been stored; done then pulses for exactly one cycle with busy
// low. start seen while busy or during done is dropped, never queued.
// Keeping start high re-triggers a load in the idle cycle after done.
//
// Modports: slave = the loader, master = sequencer/BRAM side.
// ---------------------------------------------------------------------------
interface bram_matrix_loader_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic                     start;
   logic [ADDR_W-1:0]        base_addr;
   logic                     transpose;
   logic                     busy;
   logic                     done;
   logic                     bram_en;
   logic [ADDR_W-1:0]        bram_addr;
   logic [NUM_CH*DATA_W-1:0] bram_data;

   modport slave (
      input  start, base_addr, transpose, bram_data,
      output busy, done, bram_en, bram_addr
   );

   modport master (
      output start, base_addr, transpose, bram_data,
      input  busy, done, bram_en, bram_addr
   );
endinterface

// File: rtl/bram_matrix_loader.sv
// ---------------------------------------------------------------------------
// bram_matrix_loader
//
// Streams ROWS*COLS consecutive BRAM words, starting at a programmable base
// address, from NUM_CH parallel BRAM channels that share one address, into
// register-resident matrices. The BRAM read latency is RD_LAT cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        bram_matrix_loader_if.slave: start/base_addr/transpose in,
//              busy/done out, bram_en/bram_addr out, bram_data in
//   matrix     packed [NUM_CH][ROWS][COLS][DATA_W] signed result
//   dbg_state  current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
//
// Optional feature macro: LOADER_TRANSPOSE_EN
//   defined   - transpose=1 places element k at [k%ROWS][k/ROWS]
//   undefined - transpose is ignored, placement is always [k/COLS][k%COLS],
//               and the column-major counters are not built.
// ---------------------------------------------------------------------------
module bram_matrix_loader #(
   parameter int NUM_CH = 2,
   parameter int ROWS   = 32,
   parameter int COLS   = 32,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic rst_n,
   bram_matrix_loader_if.slave bus,
   output logic signed [NUM_CH-1:0][ROWS-1:0][COLS-1:0][DATA_W-1:0] matrix,
   output logic [1:0] dbg_state
);

   localparam int N   = ROWS * COLS;
   localparam int K_W = (N > 1)      ? $clog2(N)      : 1;
   localparam int R_W = (ROWS > 1)   ? $clog2(ROWS)   : 1;
   localparam int C_W = (COLS > 1)   ? $clog2(COLS)   : 1;
   localparam int D_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [K_W-1:0]    K_LAST   = K_W'(N - 1);
   localparam logic [R_W-1:0]    R_LAST   = R_W'(ROWS - 1);
   localparam logic [C_W-1:0]    C_LAST   = C_W'(COLS - 1);
   localparam logic [D_W-1:0]    D_LAST   = D_W'(RD_LAT - 1);
   localparam logic [K_W-1:0]    K_ONE    = K_W'(1);
   localparam logic [R_W-1:0]    R_ONE    = R_W'(1);
   localparam logic [C_W-1:0]    C_ONE    = C_W'(1);
   localparam logic [D_W-1:0]    D_ONE    = D_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // The read pipeline carries the destination (row, col) of element k
   // rather than k itself, so no divide is needed when the data returns.
   typedef struct packed {
      logic           v;
      logic [R_W-1:0] r;
      logic [C_W-1:0] c;
   } pipe_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [K_W-1:0]        k_q, k_d;
   logic [R_W-1:0]        rm_r_q, rm_r_d;     // row-major row
   logic [C_W-1:0]        rm_c_q, rm_c_d;     // row-major column
   logic [D_W-1:0]        drain_q, drain_d;
   pipe_t [RD_LAT-1:0]    pipe_q, pipe_d;
   logic signed [NUM_CH-1:0][ROWS-1:0][COLS-1:0][DATA_W-1:0] matrix_q, matrix_d;

`ifdef LOADER_TRANSPOSE_EN
   logic                  tr_q, tr_d;
   logic [R_W-1:0]        tp_r_q, tp_r_d;     // column-major row
   logic [C_W-1:0]        tp_c_q, tp_c_d;     // column-major column
`else
   logic                  unused_transpose;
   assign unused_transpose = bus.transpose;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         k_q      <= '0;
         rm_r_q   <= '0;
         rm_c_q   <= '0;
         drain_q  <= '0;
         pipe_q   <= '0;
         matrix_q <= '0;
`ifdef LOADER_TRANSPOSE_EN
         tr_q     <= 1'b0;
         tp_r_q   <= '0;
         tp_c_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         k_q      <= k_d;
         rm_r_q   <= rm_r_d;
         rm_c_q   <= rm_c_d;
         drain_q  <= drain_d;
         pipe_q   <= pipe_d;
         matrix_q <= matrix_d;
`ifdef LOADER_TRANSPOSE_EN
         tr_q     <= tr_d;
         tp_r_q   <= tp_r_d;
         tp_c_q   <= tp_c_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      k_d      = k_q;
      rm_r_d   = rm_r_q;
      rm_c_d   = rm_c_q;
      drain_d  = drain_q;
      matrix_d = matrix_q;
`ifdef LOADER_TRANSPOSE_EN
      tr_d     = tr_q;
      tp_r_d   = tp_r_q;
      tp_c_d   = tp_c_q;
`endif

      // Shift the read pipeline; stage 0 is filled only while issuing.
      pipe_d[0] = '0;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      // The oldest stage lines up with the BRAM word for that read.
      if (pipe_q[RD_LAT-1].v) begin
         for (int c = 0; c < NUM_CH; c++) begin
            matrix_d[c][pipe_q[RD_LAT-1].r][pipe_q[RD_LAT-1].c] =
               bus.bram_data[c*DATA_W +: DATA_W];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_ISSUE;
               addr_d  = bus.base_addr;
               k_d     = '0;
               rm_r_d  = '0;
               rm_c_d  = '0;
               drain_d = '0;
`ifdef LOADER_TRANSPOSE_EN
               tr_d    = bus.transpose;
               tp_r_d  = '0;
               tp_c_d  = '0;
`endif
            end
         end

         S_ISSUE: begin
            pipe_d[0].v = 1'b1;
`ifdef LOADER_TRANSPOSE_EN
            pipe_d[0].r = tr_q ? tp_r_q : rm_r_q;
            pipe_d[0].c = tr_q ? tp_c_q : rm_c_q;
            if (tp_r_q == R_LAST) begin
               tp_r_d = '0;
               tp_c_d = tp_c_q + C_ONE;
            end else begin
               tp_r_d = tp_r_q + R_ONE;
            end
`else
            pipe_d[0].r = rm_r_q;
            pipe_d[0].c = rm_c_q;
`endif
            if (rm_c_q == C_LAST) begin
               rm_c_d = '0;
               rm_r_d = (rm_r_q == R_LAST) ? '0 : rm_r_q + R_ONE;
            end else begin
               rm_c_d = rm_c_q + C_ONE;
            end

            if (k_q == K_LAST) begin
               // Address holds its last value once issuing stops.
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               // Natural ADDR_W-bit overflow gives the wrap to address 0.
               addr_d = addr_q + ADDR_ONE;
               k_d    = k_q + K_ONE;
            end
         end

         S_DRAIN: begin
            if (drain_q == D_LAST) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + D_ONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.bram_en   = (state_q == S_ISSUE);
   assign bus.bram_addr = addr_q;
   assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign bus.done      = (state_q == S_DONE);
   assign matrix        = matrix_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_bram_matrix_loader.sv
// ---------------------------------------------------------------------------
// tb_bram_matrix_loader
//
// Small-shape bench (3x5 matrices, 2 channels, 6-bit addresses) with a
// behavioural BRAM of configurable read latency. Addresses and matrix
// contents are predicted per load and held in expected queues; the address
// queue drains as reads are issued, the matrix queue drains at done.
// ---------------------------------------------------------------------------
module tb_bram_matrix_loader;

   parameter int RD_LAT = 3;

   localparam int NUM_CH = 2;
   localparam int ROWS   = 3;
   localparam int COLS   = 5;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 6;
   localparam int N      = ROWS * COLS;
   localparam int BW     = NUM_CH * DATA_W;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bram_matrix_loader_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   logic signed [NUM_CH-1:0][ROWS-1:0][COLS-1:0][DATA_W-1:0] matrix;
   logic [1:0] dbg_state;

   bram_matrix_loader #(
      .NUM_CH(NUM_CH), .ROWS(ROWS), .COLS(COLS),
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .matrix    (matrix),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] model_m [NUM_CH][ROWS][COLS];
   logic [7:0]        salt_cur = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] bram_word(input logic [ADDR_W-1:0] a, input int ch);
      logic [DATA_W-1:0] w;
      w = DATA_W'(a) ^ salt_cur;
      return (ch % 2 == 0) ? w : ~w;
   endfunction

   // ---------------- BRAM model ----------------
   logic [ADDR_W-1:0] lat_addr [RD_LAT];
   logic              lat_en   [RD_LAT];
   logic [BW-1:0]     junk;

   always @(posedge clk) begin
      lat_en[0]   <= bus.bram_en;
      lat_addr[0] <= bus.bram_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         lat_en[i]   <= lat_en[i-1];
         lat_addr[i] <= lat_addr[i-1];
      end
      junk <= BW'($urandom);
   end

   // Garbage on the data bus whenever no read is returning.
   always_comb begin
      bus.bram_data = junk;
      if (lat_en[RD_LAT-1]) begin
         for (int c = 0; c < NUM_CH; c++) begin
            bus.bram_data[c*DATA_W +: DATA_W] = bram_word(lat_addr[RD_LAT-1], c);
         end
      end
   end

   // ---------------- address monitor ----------------
   always @(negedge clk) begin
      if (rst_n && bus.bram_en) begin
         if (exp_addr_q.size() == 0) check("addr_extra", 32'(bus.bram_addr), 32'hffff_ffff);
         else check("bram_addr", 32'(bus.bram_addr), 32'(exp_addr_q.pop_front()));
      end
   end

   // ---------------- model / driver tasks ----------------
   task automatic push_model();
      for (int c = 0; c < NUM_CH; c++)
         for (int r = 0; r < ROWS; r++)
            for (int col = 0; col < COLS; col++)
               exp_q.push_back(model_m[c][r][col]);
   endtask

   task automatic clear_model();
      for (int c = 0; c < NUM_CH; c++)
         for (int r = 0; r < ROWS; r++)
            for (int col = 0; col < COLS; col++)
               model_m[c][r][col] = '0;
   endtask

   task automatic model_load(input logic [ADDR_W-1:0] base, input logic tr);
      logic [ADDR_W-1:0] a;
      logic use_tr;
      int r, col;
`ifdef LOADER_TRANSPOSE_EN
      use_tr = tr;
`else
      use_tr = 1'b0 & tr;
`endif
      for (int k = 0; k < N; k++) begin
         a = base + ADDR_W'(k);
         exp_addr_q.push_back(a);
         if (use_tr) begin
            r = k % ROWS; col = k / ROWS;
         end else begin
            r = k / COLS; col = k % COLS;
         end
         for (int c = 0; c < NUM_CH; c++) model_m[c][r][col] = bram_word(a, c);
      end
      push_model();
   endtask

   task automatic compare_matrix(input string tag);
      for (int c = 0; c < NUM_CH; c++)
         for (int r = 0; r < ROWS; r++)
            for (int col = 0; col < COLS; col++) begin
               if (exp_q.size() == 0) check({tag, "_underflow"}, 32'h0, 32'h1);
               else check($sformatf("%s[%0d][%0d][%0d]", tag, c, r, col),
                          32'(matrix[c][r][col]), 32'(exp_q.pop_front()));
            end
   endtask

   task automatic run_load(input logic [ADDR_W-1:0] base, input logic tr, input logic [7:0] salt,
                           input logic hold, input logic mid_pulse);
      @(negedge clk);
      bus.base_addr = base;
      bus.transpose = tr;
      bus.start     = 1'b1;
      salt_cur      = salt;
      model_load(base, tr);
      @(posedge clk);
      #1 bus.start = hold;
      for (int j = 1; j <= N + RD_LAT + 1; j++) begin
         @(negedge clk);
         if (mid_pulse && j == N / 2) begin
            bus.start     = 1'b1;
            bus.base_addr = ADDR_W'($urandom);
            bus.transpose = ~tr;
         end
         if (mid_pulse && j == N / 2 + 1) bus.start = 1'b0;
         check("busy", 32'(bus.busy), 32'(j <= N + RD_LAT));
         check("done", 32'(bus.done), 32'(j == N + RD_LAT + 1));
      end
      compare_matrix("matrix");
      check("addr_left", 32'(exp_addr_q.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < RD_LAT; i++) begin
         lat_en[i]   = 1'b0;
         lat_addr[i] = '0;
      end
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.transpose = 1'b0;

      // reset values
      #1;
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_en",    32'(bus.bram_en), 32'd0);
      check("rst_addr",  32'(bus.bram_addr), 32'd0);
      clear_model();
      push_model();
      compare_matrix("rst_matrix");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // plain, wrap-around, transposed, ignored mid-load start
      run_load(6'd0,  1'b0, 8'h00, 1'b0, 1'b0);
      run_load(6'd58, 1'b0, 8'h5a, 1'b0, 1'b0);
      run_load(6'd7,  1'b1, 8'h33, 1'b0, 1'b0);
      run_load(6'd20, 1'b0, 8'hc4, 1'b0, 1'b1);

      // start held high: back-to-back loads
      run_load(6'd3,  1'b1, 8'h11, 1'b1, 1'b0);
      run_load(6'd40, 1'b0, 8'h22, 1'b1, 1'b0);
      run_load(6'd61, 1'b1, 8'h99, 1'b0, 1'b0);

      // reset in the middle of ISSUE
      @(negedge clk);
      bus.base_addr = 6'd11;
      bus.transpose = 1'b0;
      bus.start     = 1'b1;
      salt_cur      = 8'h77;
      for (int k = 0; k < N; k++) exp_addr_q.push_back(6'd11 + ADDR_W'(k));
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (N / 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_addr_q.delete();
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      check("mid_rst_busy",  32'(bus.busy), 32'd0);
      check("mid_rst_done",  32'(bus.done), 32'd0);
      check("mid_rst_en",    32'(bus.bram_en), 32'd0);
      check("mid_rst_addr",  32'(bus.bram_addr), 32'd0);
      clear_model();
      push_model();
      compare_matrix("mid_rst_matrix");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (RD_LAT + 1) @(negedge clk);
      check("post_rst_matrix_zero", 32'(|matrix), 32'd0);
      run_load(6'd50, 1'b0, 8'h3c, 1'b0, 1'b0);

      // random loads
      for (int i = 0; i < 4; i++) begin
         run_load(ADDR_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
